// File: rtl/imem_boot_pkg.sv
// Shared types and defaults for the instruction-memory boot sequencer.
package imem_boot_pkg;

  localparam int IMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COPY  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } boot_state_e;

endpackage

// File: rtl/imem_boot_ctrl.sv
// Boot sequencer: copies loader ROM words 0..MAX_ADDRESS-1 into imem with the CPU stalled.
// Optional running checksum of written words when IMEM_BOOT_CHECKSUM_EN is defined.
//
// state | meaning
// IDLE  | after reset; waits for start (or auto start once)
// COPY  | presents rd_ptr to the ROM, one word per cycle
// DRAIN | final write of word MAX_ADDRESS-1 lands
// DONE  | CPU released, imem address port follows cpu_pc
module imem_boot_ctrl
  import imem_boot_pkg::*;
#(
  parameter int MAX_ADDRESS = 64,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = IMEM_DATA_W,
  parameter bit AUTO_START  = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  input  logic [ADDR_W-1:0] cpu_pc,
  output logic              cpu_stall,
  output logic              loading,
  output logic              done
`ifdef IMEM_BOOT_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam int RPW = (MAX_ADDRESS > 1) ? $clog2(MAX_ADDRESS) : 1;
  localparam logic [RPW-1:0] LAST = RPW'(MAX_ADDRESS - 1);

  boot_state_e    state, state_nx;
  logic [RPW-1:0] rd_ptr;
  logic [RPW-1:0] wr_addr;
  logic           wr_valid;
  logic           auto_pend;
  logic           enter_copy;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      wr_addr   <= '0;
      wr_valid  <= 1'b0;
      auto_pend <= 1'b1;
    end else begin
      state    <= state_nx;
      // ROM data arrives one cycle after its address, so the write trails the read by one
      wr_valid <= (state == COPY);
      if (enter_copy) auto_pend <= 1'b0;
      if (state == COPY) begin
        wr_addr <= rd_ptr;
        rd_ptr  <= (rd_ptr == LAST) ? '0 : rd_ptr + RPW'(1);
      end else if (enter_copy) begin
        rd_ptr <= '0;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    enter_copy = 1'b0;
    case (state)
      IDLE: begin
        if (start || (AUTO_START && auto_pend)) begin
          state_nx   = COPY;
          enter_copy = 1'b1;
        end
      end
      COPY:  if (rd_ptr == LAST) state_nx = DRAIN;
      DRAIN: state_nx = DONE;
      DONE: begin
        if (start) begin
          state_nx   = COPY;
          enter_copy = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign rom_addr   = (state == COPY) ? ADDR_W'(rd_ptr) : '0;
  assign imem_we    = wr_valid;
  assign imem_addr  = (state == DONE) ? cpu_pc : ADDR_W'(wr_addr);
  assign imem_wdata = rom_data;
  assign cpu_stall  = (state != DONE);
  assign loading    = (state == COPY) || (state == DRAIN);
  assign done       = (state == DONE);

`ifdef IMEM_BOOT_CHECKSUM_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      checksum <= '0;
    end else if (enter_copy) begin
      checksum <= '0;
    end else if (wr_valid) begin
      checksum <= checksum + rom_data;
    end
  end
`endif

endmodule

// File: doc/imem_boot_ctrl.md
Name: imem_boot_ctrl

Overview:
Boot-time sequencer for instruction memory in the MIPS FPGA design. Walks word addresses 0..MAX_ADDRESS-1 of the instruction source ROM (the instr_loader image) and copies each word into instruction memory, with the CPU held in stall. After the copy completes, it releases the CPU and hands the imem address port to the CPU fetch PC. The block sits between the loader ROM, instruction memory and the CPU fetch stage.

Parameters:
MAX_ADDRESS, 64, number of instruction words to copy (>=1)
ADDR_W, 32, width of word addresses on all address ports
DATA_W, 32, instruction word width
AUTO_START, 1, 1 = begin a copy on the first clock after reset without needing start

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request a (re)load; sampled in IDLE and DONE only
rom_addr  out  ADDR_W  word address into the loader ROM
rom_data  in  DATA_W  ROM word; valid the cycle after rom_addr is presented
imem_we  out  1  instruction-memory write enable
imem_addr  out  ADDR_W  instruction-memory word address
imem_wdata  out  DATA_W  instruction-memory write data
cpu_pc  in  ADDR_W  CPU fetch word address
cpu_stall  out  1  holds the CPU while not DONE
loading  out  1  high in COPY and DRAIN
done  out  1  high in DONE

Behaviour:
- States: IDLE, COPY, DRAIN, DONE. Asynchronous reset forces IDLE, rd_ptr=0, wr_valid=0, wr_addr=0.
- Reset values: imem_we=0, cpu_stall=1, loading=0, done=0, rom_addr=0, imem_addr=0, imem_wdata=rom_data (don't-care).
- IDLE: if start or AUTO_START, go to COPY with rd_ptr=0. AUTO_START applies only to the first exit from IDLE after reset.
- COPY: rom_addr=rd_ptr, zero-extended to ADDR_W. Each cycle: rd_ptr+1, wr_addr<=rd_ptr, wr_valid<=1. When rd_ptr==MAX_ADDRESS-1, go to DRAIN and set rd_ptr=0 (wrap).
- Write stage in all states: imem_we=wr_valid, imem_addr=wr_addr, imem_wdata=rom_data (combinational pass-through). This gives 1 word per cycle.
- DRAIN: performs the final write (address MAX_ADDRESS-1), clears wr_valid, then goes to DONE.
- DONE: cpu_stall=0, done=1, imem_we=0, imem_addr=cpu_pc (combinational mux), rom_addr=0.
- start in DONE: go to COPY. cpu_stall rises and done falls in the same cycle COPY is entered.
- Latency: when start is sampled at edge E, address k is written in cycle E+1+k. done rises at edge E+MAX_ADDRESS+1. Every address is written exactly once per load.
- start in COPY or DRAIN is ignored and is not queued.
- Reset mid-copy: imem_we drops immediately (asynchronously) and no partial write completes. After reset, the block behaves as after power-up.
- MAX_ADDRESS=1: COPY lasts one cycle, then DRAIN, then DONE.
- rd_ptr width: clog2(MAX_ADDRESS), minimum 1 bit. The zero-extension of rd_ptr to ADDR_W is explicit.

Optional Feature:
- Macro: IMEM_BOOT_CHECKSUM_EN.
- Defined: adds output checksum [DATA_W-1:0]. It holds the sum mod 2^DATA_W of every word written in the current load. It is cleared to 0 on entry to COPY, accumulates on each imem_we cycle, and is stable and valid while done=1. Its reset value is 0.
- Undefined: the port and the accumulator are absent, and all other behaviour is identical.

Decomposition:
- Package imem_boot_pkg holds the state enum (IDLE, COPY, DRAIN, DONE) and the DATA_W default constant.
- Sub-module: none. The counter and the write-stage register are inline.

Test Plan:
- Reset release, MAX_ADDRESS=8, AUTO_START=1, ROM word k = 32'hA000_0000+k -> imem writes addresses 0..7 with matching data on consecutive cycles; done rises 9 clocks after the first edge; cpu_stall=0 from then on.
- AUTO_START=0 with start held low for 20 cycles -> stays in IDLE, imem_we=0, cpu_stall=1. A 1-cycle start pulse -> the copy sequence above.
- In DONE, drive cpu_pc=5 -> imem_addr=5 and imem_we=0. Then pulse start -> cpu_stall=1 the next cycle and the full 8-word reload.
- Pulse start at copy cycle 3 -> ignored; exactly 8 writes occur and done timing is unchanged.
- Assert reset during copy cycle 4 -> imem_we=0 immediately; after release, the copy restarts at address 0.
- MAX_ADDRESS=1 -> a single write to address 0; done rises 2 clocks after start. With IMEM_BOOT_CHECKSUM_EN and 8 words 1..8, checksum reads 36.
